// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
//   DATA_W   : writeback data width
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers (2**ADDR_W)
//   REQ_ALU  : requester index of the main pipeline (ALU/load result)
//   REQ_LL   : requester index of the long-latency unit (mul/div)
package regfile_wb_arbiter_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LL  = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, reusable for any shared single-port resource.
//   clk, rst : clock, synchronous active-high reset
//   valid    : [1:0] request lines
//   grant    : [1:0] one-hot grant (combinational), zero when nobody asks
//   favoured : index of the requester that wins the next conflict
//
// A grant is a completed handshake: the consumer behind this arbiter never
// stalls, so grant[i] doubles as ready for requester i.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       favoured
);

  // The register holds the requester that wins a tie. After any grant the
  // other requester becomes favoured, so the winner drops to lowest priority.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (favoured == REQ_LL) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      favoured <= REQ_ALU;
    end else if (grant != 2'b00) begin
      favoured <= grant[0] ? REQ_LL : REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the main pipeline
// (req0) and the long-latency unit (req1), and keeps a pending-write
// scoreboard for RAW-hazard stalls in the issue stage.
//   clk, rst                  : clock, synchronous active-high reset
//   reqN_valid/ready/addr/data: writeback requesters (ready combinational)
//   reserve_valid/addr        : issue stage marks a register as pending
//   RegWrite/WriteReg/WriteData: registered register-file write port
//   busy_mask                 : bit i set while a write to reg i is pending
//   sb_err                    : sticky, set when a reserve hits a busy reg
//
// Handshake: a requester's write transfers on a rising edge where both its
// valid and ready are high. ready depends only on the valid inputs and the
// arbitration pointer, never on ready, and the register file never stalls.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  input  logic                 reserve_valid,
  input  logic [ADDR_W-1:0]    reserve_addr,
  output logic                 RegWrite,
  output logic [ADDR_W-1:0]    WriteReg,
  output logic [DATA_W-1:0]    WriteData,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic                 sb_err
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [1:0]        reqValid;
  logic [1:0]        grant;
  logic              favoured;
  logic              handshake;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;

  assign reqValid = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid    (reqValid),
    .grant    (grant),
    .favoured (favoured)
  );

  assign req0_ready = grant[REQ_ALU];
  assign req1_ready = grant[REQ_LL];
  assign handshake  = |grant;
  assign selAddr    = grant[REQ_LL] ? req1_addr : req0_addr;
  assign selData    = grant[REQ_LL] ? req1_data : req0_data;

  // Output stage. Register 0 is hardwired, so an address-0 grant is
  // consumed here without ever raising the write enable. Without a
  // handshake the address/data hold so the port stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (handshake) begin
      RegWrite  <= (selAddr != '0);
      WriteReg  <= selAddr;
      WriteData <= selData;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  // Scoreboard. Clear is applied before set so that a reservation landing
  // on the same edge as the commit of the previous write survives.
  logic [NREGS-1:0] busyNext;
  logic             reserveLive;
  logic             reserveHitBusy;

  assign reserveLive    = reserve_valid && (reserve_addr != '0);
  assign reserveHitBusy = reserveLive && busy_mask[reserve_addr];

  always_comb begin
    busyNext = busy_mask;
    if (RegWrite) begin
      busyNext[WriteReg] = 1'b0;
    end
    if (reserveLive) begin
      busyNext[reserve_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_mask <= '0;
      sb_err    <= 1'b0;
    end else begin
      busy_mask <= busyNext;
      if (reserveHitBusy) begin
        sb_err <= 1'b1;
      end
    end
  end

  // The arbitration pointer is internal to the arbiter; it is brought out
  // so it can be probed, but the top has no further use for it.
  logic unusedFavoured;
  assign unusedFavoured = favoured;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid, req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          reserve_valid;
  logic [AW-1:0] reserve_addr;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [NR-1:0] busy_mask;
  logic          sb_err;

  int errCount   = 0;
  int checkCount = 0;

  // clock / reset block
  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_addr     (req0_addr),
    .req0_data     (req0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_addr     (req1_addr),
    .req1_data     (req1_data),
    .reserve_valid (reserve_valid),
    .reserve_addr  (reserve_addr),
    .RegWrite      (RegWrite),
    .WriteReg      (WriteReg),
    .WriteData     (WriteData),
    .busy_mask     (busy_mask),
    .sb_err        (sb_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid    = 1'b0;
    req1_valid    = 1'b0;
    reserve_valid = 1'b0;
  endtask

  task automatic drive0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = 1'b1;
    req0_addr  = a;
    req0_data  = d;
  endtask

  task automatic drive1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = 1'b1;
    req1_addr  = a;
    req1_data  = d;
  endtask

  task automatic reserve(input logic [AW-1:0] a);
    reserve_valid = 1'b1;
    reserve_addr  = a;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [1:0] expGrant [4];
  logic [NR-1:0] bit7, bit9;

  initial begin
    expGrant[0] = 2'b01;
    expGrant[1] = 2'b10;
    expGrant[2] = 2'b01;
    expGrant[3] = 2'b10;
    bit7 = '0;
    bit7[7] = 1'b1;
    bit9 = '0;
    bit9[9] = 1'b1;
    req0_addr = '0; req0_data = '0;
    req1_addr = '0; req1_data = '0;
    reserve_addr = '0;
    #1;

    // reset state
    do_reset();
    check("rst_regwrite", RegWrite, 0);
    check("rst_writereg", WriteReg, 0);
    check("rst_writedata", WriteData, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_sberr", sb_err, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);

    // single write from req0
    drive0(5'd5, 32'hDEADBEEF);
    #1;
    check("single_ready0", req0_ready, 1);
    check("single_ready1", req1_ready, 0);
    step();
    idle();
    check("single_regwrite", RegWrite, 1);
    check("single_writereg", WriteReg, 5);
    check("single_writedata", WriteData, 32'hDEADBEEF);
    step();
    check("idle_regwrite", RegWrite, 0);
    check("idle_hold_reg", WriteReg, 5);
    check("idle_hold_data", WriteData, 32'hDEADBEEF);

    // four-cycle conflict after reset: 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive0(5'd1, 32'h0000_0011);
      drive1(5'd2, 32'h0000_0022);
      #1;
      check($sformatf("rr_ready0_%0d", i), req0_ready, expGrant[i][0]);
      check($sformatf("rr_ready1_%0d", i), req1_ready, expGrant[i][1]);
      step();
      check($sformatf("rr_regwrite_%0d", i), RegWrite, 1);
      check($sformatf("rr_writereg_%0d", i), WriteReg, expGrant[i][0] ? 5'd1 : 5'd2);
      check($sformatf("rr_writedata_%0d", i), WriteData,
            expGrant[i][0] ? 32'h11 : 32'h22);
    end
    idle();
    step();

    // last grant was req1, so req0 wins; then an addr-0 grant to req1
    drive0(5'd1, 32'h0000_0011);
    drive1(5'd2, 32'h0000_0022);
    #1;
    check("pre_zero_ready0", req0_ready, 1);
    step();
    idle();
    drive1(5'd0, 32'h0000_1234);
    #1;
    check("zero_ready1", req1_ready, 1);
    step();
    idle();
    check("zero_regwrite", RegWrite, 0);
    check("zero_writedata", WriteData, 32'h1234);
    check("zero_busy", busy_mask, 0);
    drive0(5'd1, 32'h0000_0011);
    drive1(5'd2, 32'h0000_0022);
    #1;
    check("post_zero_ready0", req0_ready, 1);
    check("post_zero_ready1", req1_ready, 0);
    step();
    idle();
    step();

    // reserve 7, write 7 three cycles later
    reserve(5'd7);
    step();
    idle();
    check("res7_set", busy_mask, bit7);
    step();
    step();
    drive0(5'd7, 32'h0000_0077);
    step();
    idle();
    check("res7_regwrite", RegWrite, 1);
    check("res7_writereg", WriteReg, 7);
    check("res7_still_busy", busy_mask, bit7);
    step();
    check("res7_cleared", busy_mask, 0);
    check("res7_sberr", sb_err, 0);

    // write to 9 commits on the same edge as a reserve of 9
    drive0(5'd9, 32'h0000_0099);
    step();
    idle();
    check("same_regwrite", RegWrite, 1);
    check("same_writereg", WriteReg, 9);
    reserve(5'd9);
    step();
    idle();
    check("same_busy9", busy_mask, bit9);
    check("same_sberr", sb_err, 0);
    reserve(5'd9);
    step();
    idle();
    check("dup_sberr", sb_err, 1);
    check("dup_busy9", busy_mask, bit9);
    step();
    check("dup_sberr_sticky", sb_err, 1);

    // reserve of register 0 is ignored
    reserve(5'd0);
    step();
    idle();
    check("res0_busy", busy_mask, bit9);

    // reset right after a handshake to reg 3
    drive1(5'd3, 32'h0000_0033);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_regwrite", RegWrite, 0);
    check("rst2_writereg", WriteReg, 0);
    check("rst2_busy", busy_mask, 0);
    check("rst2_sberr", sb_err, 0);
    drive0(5'd1, 32'h0000_0011);
    drive1(5'd2, 32'h0000_0022);
    #1;
    check("rst2_ready0", req0_ready, 1);
    check("rst2_ready1", req1_ready, 0);
    step();
    idle();
    step();

    // final report
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
